// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder datapath: state encoding,
// default operand width and a counter-width helper.
package adder_pkg;

  // Default operand/accumulator width used when a parent does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Batch controller state encoding.
  localparam logic ST_ACC  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  typedef enum logic {
    S_ACC  = ST_ACC,
    S_HOLD = ST_HOLD
  } state_t;

  // Bits needed to count 0..count inclusive.
  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/rca_nbit.sv
// N-bit ripple-carry adder: a chain of full adders, carry rippling from bit 0
// upwards. Purely combinational.
module rca_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  // Full-adder chain; each stage consumes the carry of the stage below.
  always_comb begin
    w_carry    = '0;
    sum        = '0;
    w_carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
    end
  end

  assign cout = w_carry[WIDTH];

endmodule

// File: rtl/rca_accum_ctrl.sv
// Streaming batch accumulator. Sums COUNT operands modulo 2^WIDTH through an
// rca_nbit instance, tracks a sticky carry-out flag, then offers the batch
// result on the output until the sink takes it.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer holds valid and its data
// stable until that edge. Here in_ready and out_valid depend only on state, so
// neither port has a combinational path from valid to ready; a result is only
// presented the cycle after the last operand, and a new batch only opens the
// cycle after the result is taken.
module rca_accum_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             dbg_state
);

  localparam int            CW   = cnt_width(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_release;

  // Datapath add: running accumulator plus the incoming operand.
  rca_nbit #(
    .WIDTH (WIDTH)
  ) u_rca (
    .a    (r_acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Port decode is a pure function of state.
  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_HOLD);
  assign out_sum   = out_valid ? r_acc : '0;
  assign out_ovf   = out_valid & r_ovf;
  assign dbg_state = r_state;

  assign w_accept  = in_valid & in_ready;
  assign w_release = out_valid & out_ready;

  // Next-state and datapath update; clear overrides any handshake this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = S_ACC;
      w_acc_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            w_acc_nxt = w_sum;
            w_ovf_nxt = r_ovf | w_cout;
            if (r_cnt == LAST) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_HOLD;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_release) begin
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = S_ACC;
          end
        end
        default: begin
          w_state_nxt = S_ACC;
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State registers; async reset drops any partial batch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACC;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rca_accum_ctrl.sv
// Bench for rca_accum_ctrl: one instance with COUNT=4 and one with COUNT=1,
// both WIDTH=4, checked every cycle against a batch-level reference model.
module tb_rca_accum_ctrl;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_sum   [2];
  logic         out_ovf   [2];
  logic         dbg_state [2];

  rca_accum_ctrl #(.WIDTH(W), .COUNT(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_sum   (out_sum[0]),
    .out_ovf   (out_ovf[0]),
    .dbg_state (dbg_state[0])
  );

  rca_accum_ctrl #(.WIDTH(W), .COUNT(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_sum   (out_sum[1]),
    .out_ovf   (out_ovf[1]),
    .dbg_state (dbg_state[1])
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  logic [W:0] exp_q  [$];   // {ovf, sum} pending for the COUNT=4 instance
  logic [W:0] exp_q1 [$];   // {ovf, sum} pending for the COUNT=1 instance

  int m_acc  [2];
  int m_cnt  [2];
  bit m_ovf  [2];
  bit m_pend [2];
  int lim    [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W:0] exp_front(input int k);
    return (k == 0) ? exp_q[0] : exp_q1[0];
  endfunction

  task automatic model_clear(input int k);
    m_acc[k]  = 0;
    m_cnt[k]  = 0;
    m_ovf[k]  = 1'b0;
    m_pend[k] = 1'b0;
    if (k == 0) exp_q.delete();
    else        exp_q1.delete();
  endtask

  // Called just after a falling edge with inputs already set: checks outputs
  // against the model, advances the model over the coming rising edge, and
  // returns at the next falling edge.
  task automatic tick();
    logic [W:0] e;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("in_ready[%0d]", k), in_ready[k], !m_pend[k]);
      check_eq($sformatf("out_valid[%0d]", k), out_valid[k], m_pend[k]);
      check_eq($sformatf("dbg_state[%0d]", k), dbg_state[k], m_pend[k]);
      if (m_pend[k]) begin
        e = exp_front(k);
        check_eq($sformatf("out_sum[%0d]", k), out_sum[k], e[W-1:0]);
        check_eq($sformatf("out_ovf[%0d]", k), out_ovf[k], e[W]);
      end
      if (clear) begin
        model_clear(k);
      end else if (m_pend[k]) begin
        if (out_ready[k]) begin
          if (k == 0) begin
            void'(exp_q.pop_front());
            n_done++;
          end else begin
            void'(exp_q1.pop_front());
          end
          m_pend[k] = 1'b0;
        end
      end else if (in_valid[k]) begin
        m_acc[k] = m_acc[k] + int'(in_data[k]);
        if (m_acc[k] >= MOD) begin
          m_acc[k] = m_acc[k] - MOD;
          m_ovf[k] = 1'b1;
        end
        m_cnt[k]++;
        if (m_cnt[k] == lim[k]) begin
          e = {m_ovf[k], W'(m_acc[k])};
          if (k == 0) exp_q.push_back(e);
          else        exp_q1.push_back(e);
          m_pend[k] = 1'b1;
          m_acc[k]  = 0;
          m_ovf[k]  = 1'b0;
          m_cnt[k]  = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_both(input logic v, input logic [W-1:0] d, input logic r);
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = v;
      in_data[k]   = d;
      out_ready[k] = r;
    end
  endtask

  // Feed four operands back-to-back, check the result directly the cycle
  // after the last accept, stall the sink n_stall cycles, then release it.
  task automatic feed4(input int a, input int b, input int c, input int d,
                       input int exp_sum, input bit exp_ovf, input int n_stall,
                       input string name);
    int ops[4];
    ops = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      set_both(1'b1, W'(ops[i]), 1'b0);
      tick();
    end
    for (int s = 0; s < n_stall; s++) begin
      set_both(1'b1, W'($urandom), 1'b0);
      #1;
      check_eq({name, "_valid"}, out_valid[0], 1);
      check_eq({name, "_sum"}, out_sum[0], exp_sum);
      check_eq({name, "_ovf"}, out_ovf[0], exp_ovf);
      check_eq({name, "_in_ready_low"}, in_ready[0], 0);
      tick();
    end
    set_both(1'b0, '0, 1'b1);
    tick();
    set_both(1'b0, '0, 1'b0);
    #1;
    check_eq({name, "_in_ready_after"}, in_ready[0], 1);
    check_eq({name, "_valid_after"}, out_valid[0], 0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    lim[0] = 4;
    lim[1] = 1;
    model_clear(0);
    model_clear(1);
    set_both(1'b0, '0, 1'b0);

    // reset values
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_out_valid[%0d]", k), out_valid[k], 0);
      check_eq($sformatf("rst_out_sum[%0d]", k), out_sum[k], 0);
      check_eq($sformatf("rst_out_ovf[%0d]", k), out_ovf[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // directed batches
    feed4(1, 2, 3, 4, 10, 1'b0, 5, "b1234");
    feed4(3, 5, 7, 1, 0, 1'b1, 1, "b3571");
    feed4(15, 1, 0, 0, 0, 1'b1, 1, "b15100");

    // idle cycles leave everything unchanged
    set_both(1'b0, 4'hF, 1'b0);
    repeat (3) tick();

    // clear mid-batch with a same-cycle operand
    set_both(1'b1, 4'd2, 1'b1);
    tick();
    tick();
    clear = 1'b1;
    set_both(1'b1, 4'd5, 1'b1);
    tick();
    clear = 1'b0;
    set_both(1'b0, '0, 1'b0);
    #1;
    check_eq("clear_out_valid", out_valid[0], 0);
    check_eq("clear_in_ready", in_ready[0], 1);
    tick();
    feed4(1, 1, 1, 1, 4, 1'b0, 1, "after_clear");

    // async reset mid-batch
    set_both(1'b1, 4'd9, 1'b1);
    tick();
    tick();
    set_both(1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid[0], 0);
    check_eq("arst_out_sum", out_sum[0], 0);
    model_clear(0);
    model_clear(1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("arst_in_ready", in_ready[0], 1);
    @(negedge clk);
    feed4(1, 1, 1, 1, 4, 1'b0, 1, "after_rst");

    // randomised traffic with gaps, stalls and rare clears
    n_done = 0;
    cyc    = 0;
    while (n_done < 100 && cyc < 20000) begin
      clear = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 9) < 7);
        in_data[k]   = W'($urandom);
        out_ready[k] = ($urandom_range(0, 9) < 6);
      end
      tick();
      cyc++;
    end
    clear = 1'b0;
    check_eq("random_batches_done", (n_done >= 100), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
